// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_latency_timer.sv
// Down-counter tracking the in-flight memory access; last marks the response cycle.
module mem_port_latency_timer
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    // A load on the response cycle restarts the count for a back-to-back access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one fixed-latency transaction in flight, with a bounded data burst when fetch waits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_VAL   = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_D_BURST);

    state_t           state, state_n;
    owner_t           owner, owner_n;
    logic [CNT_W-1:0] scnt, scnt_n;
    logic             wr_flag, wr_flag_n;

    logic last;
    logic resp;
    logic can_grant;
    logic d_wins;
    logic gnt_if;
    logic gnt_d;

    mem_port_latency_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (gnt_if | gnt_d),
        .load_val (LAT_VAL),
        .last     (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= OWN_IF;
            scnt    <= '0;
            wr_flag <= 1'b0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            scnt    <= scnt_n;
            wr_flag <= wr_flag_n;
        end
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        scnt_n    = scnt;
        wr_flag_n = wr_flag;

        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        if_stall  = 1'b0;
        d_stall   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;

        // Outputs are held low while reset is asserted, even with requests present.
        resp      = !reset && (state == BUSY) && last;
        can_grant = !reset && ((state == IDLE) || resp);
        d_wins    = d_req && (!if_req || (scnt != BURST_MAX));
        gnt_d     = can_grant && d_wins;
        gnt_if    = can_grant && if_req && !d_wins;

        if (resp) begin
            if (owner == OWN_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = wr_flag ? 32'h0 : mem_rdata;
            end
        end

        if (gnt_d) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
            owner_n   = OWN_D;
            wr_flag_n = d_we;
            if (if_req) begin
                scnt_n = (scnt == BURST_MAX) ? scnt : scnt + 1'b1;
            end else begin
                scnt_n = '0;
            end
        end else if (gnt_if) begin
            if_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            owner_n   = OWN_IF;
            wr_flag_n = 1'b0;
            scnt_n    = '0;
        end

        if (gnt_d || gnt_if) begin
            state_n = BUSY;
        end else if (resp) begin
            state_n = IDLE;
        end

        if (!reset) begin
            if_stall = (if_req && !if_rvalid) ||
                       ((state == BUSY) && (owner == OWN_IF) && !last);
            d_stall  = (d_req && !d_rvalid) ||
                       ((state == BUSY) && (owner == OWN_D) && !last);
        end
    end

endmodule
